// File: rtl/control_unit.sv
// Multi-cycle RISC-V control FSM: sequences fetch/decode/execute/memory/
// write-back and retires instructions with a one-cycle finished pulse.
module control_unit #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run,
  input  logic [6:0]             opcode,
  output logic                   fetch,
  output logic                   decode,
  output logic                   dm_write_en,
  output logic                   rf_write_en,
  output logic                   mem_to_reg,
  output logic                   finished,
  output logic                   halted,
  output logic                   illegal,
  output logic [3:0]             state,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    EXECUTE   = 4'd3,
    MEMORY    = 4'd4,
    WRITEBACK = 4'd5,
    COMPLETE  = 4'd6,
    HALT      = 4'd7,
    ERROR     = 4'd8
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_R32   = 7'b0111011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_I32   = 7'b0011011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  localparam logic [COUNT_WIDTH-1:0] ONE =
    {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  state_t     cur;
  state_t     nxt;
  logic [6:0] opcode_q;
  logic       legal;

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_R, OP_R32, OP_I, OP_I32,
      OP_LOAD, OP_STORE, OP_BR,
      OP_JAL, OP_JALR, OP_LUI,
      OP_AUIPC, OP_SYS: legal = 1'b1;
      default:          legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur         <= IDLE;
      opcode_q    <= 7'd0;
      instr_count <= '0;
    end else begin
      cur <= nxt;
      if (cur == DECODE)
        opcode_q <= opcode;
      if (cur == COMPLETE)
        instr_count <= instr_count + ONE;
    end
  end

  always_comb begin
    nxt = IDLE;
    unique case (cur)
      IDLE:      nxt = run ? FETCH : IDLE;
      FETCH:     nxt = DECODE;
      DECODE: begin
        unique case (1'b1)
          opcode == OP_SYS: nxt = HALT;
          !legal:           nxt = ERROR;
          default:          nxt = EXECUTE;
        endcase
      end
      EXECUTE: begin
        unique case (1'b1)
          opcode_q == OP_LOAD,
          opcode_q == OP_STORE: nxt = MEMORY;
          opcode_q == OP_BR:    nxt = COMPLETE;
          default:              nxt = WRITEBACK;
        endcase
      end
      MEMORY:
        nxt = (opcode_q == OP_STORE) ? COMPLETE : WRITEBACK;
      WRITEBACK: nxt = COMPLETE;
      COMPLETE:  nxt = run ? FETCH : IDLE;
      HALT:      nxt = HALT;
      ERROR:     nxt = ERROR;
      default:   nxt = IDLE;
    endcase
  end

  // Strobes decode only registered state, so reset kills them at once.
  always_comb begin
    fetch       = (cur == FETCH);
    decode      = (cur == DECODE);
    dm_write_en = (cur == MEMORY) && (opcode_q == OP_STORE);
    rf_write_en = (cur == WRITEBACK);
    mem_to_reg  = (cur == WRITEBACK) && (opcode_q == OP_LOAD);
    finished    = (cur == COMPLETE);
    halted      = (cur == HALT);
    illegal     = (cur == ERROR);
    state       = cur;
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-opcode state/strobe tables plus
// hand sequences for back-to-back, run drop, reset abort and count wrap.
module tb_control_unit;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0;
  logic [6:0]    opcode = 7'd0;
  logic          fetch, decode, dm_write_en, rf_write_en;
  logic          mem_to_reg, finished, halted, illegal;
  logic [3:0]    state;
  logic [CW-1:0] instr_count;

  int errors = 0;
  int checks = 0;

  control_unit #(.COUNT_WIDTH(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .opcode      (opcode),
    .fetch       (fetch),
    .decode      (decode),
    .dm_write_en (dm_write_en),
    .rf_write_en (rf_write_en),
    .mem_to_reg  (mem_to_reg),
    .finished    (finished),
    .halted      (halted),
    .illegal     (illegal),
    .state       (state),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] BR    = 7'b1100011;
  localparam logic [6:0] ALU   = 7'b0110011;

  typedef struct {
    logic [6:0]      op;
    int              len;
    logic [0:5][3:0] seq;
    logic [3:0]      nxt;
    logic [3:0]      cnt;
  } vec_t;

  vec_t vecs [14];

  function automatic logic [11:0] model(input logic [3:0] s,
                                        input logic [6:0] op);
    return {s, s == 4'd1, s == 4'd2,
            (s == 4'd4) && (op == STORE), s == 4'd5,
            (s == 4'd5) && (op == LOAD), s == 4'd6,
            s == 4'd7, s == 4'd8};
  endfunction

  function automatic logic [11:0] outs();
    return {state, fetch, decode, dm_write_en, rf_write_en,
            mem_to_reg, finished, halted, illegal};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    run   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{ALU,        5, {4'd1,4'd2,4'd3,4'd5,4'd6,4'd0}, 4'd1, 4'd1};
    vecs[1]  = '{7'b0111011, 5, {4'd1,4'd2,4'd3,4'd5,4'd6,4'd0}, 4'd1, 4'd1};
    vecs[2]  = '{7'b0010011, 5, {4'd1,4'd2,4'd3,4'd5,4'd6,4'd0}, 4'd1, 4'd1};
    vecs[3]  = '{7'b0011011, 5, {4'd1,4'd2,4'd3,4'd5,4'd6,4'd0}, 4'd1, 4'd1};
    vecs[4]  = '{7'b1101111, 5, {4'd1,4'd2,4'd3,4'd5,4'd6,4'd0}, 4'd1, 4'd1};
    vecs[5]  = '{7'b1100111, 5, {4'd1,4'd2,4'd3,4'd5,4'd6,4'd0}, 4'd1, 4'd1};
    vecs[6]  = '{7'b0110111, 5, {4'd1,4'd2,4'd3,4'd5,4'd6,4'd0}, 4'd1, 4'd1};
    vecs[7]  = '{7'b0010111, 5, {4'd1,4'd2,4'd3,4'd5,4'd6,4'd0}, 4'd1, 4'd1};
    vecs[8]  = '{LOAD,       6, {4'd1,4'd2,4'd3,4'd4,4'd5,4'd6}, 4'd1, 4'd1};
    vecs[9]  = '{STORE,      5, {4'd1,4'd2,4'd3,4'd4,4'd6,4'd0}, 4'd1, 4'd1};
    vecs[10] = '{BR,         4, {4'd1,4'd2,4'd3,4'd6,4'd0,4'd0}, 4'd1, 4'd1};
    vecs[11] = '{7'b1110011, 6, {4'd1,4'd2,4'd7,4'd7,4'd7,4'd7}, 4'd7, 4'd0};
    vecs[12] = '{7'b1111111, 6, {4'd1,4'd2,4'd8,4'd8,4'd8,4'd8}, 4'd8, 4'd0};
    vecs[13] = '{7'b0000000, 6, {4'd1,4'd2,4'd8,4'd8,4'd8,4'd8}, 4'd8, 4'd0};

    // Reset holds everything low even with run and a valid opcode
    rst_n  = 1'b0;
    run    = 1'b1;
    opcode = ALU;
    repeat (3) tick();
    chk("reset_outs", 32'(outs()), 32'(model(4'd0, ALU)));
    chk("reset_cnt", 32'(instr_count), 32'd0);

    for (int v = 0; v < 14; v++) begin
      do_reset();
      opcode = vecs[v].op;
      run    = 1'b1;
      for (int c = 0; c < vecs[v].len; c++) begin
        tick();
        chk($sformatf("vec%0d_cyc%0d", v, c + 1), 32'(outs()),
            32'(model(vecs[v].seq[c], vecs[v].op)));
      end
      tick();
      chk($sformatf("vec%0d_next", v), 32'(state), 32'(vecs[v].nxt));
      chk($sformatf("vec%0d_cnt", v), 32'(instr_count),
          32'(vecs[v].cnt));
      run = 1'b0;
    end

    // LOAD then STORE back to back
    do_reset();
    opcode = LOAD;
    run    = 1'b1;
    repeat (6) tick();
    chk("ls_load_fin", 32'({state, finished}), 32'({4'd6, 1'b1}));
    opcode = STORE;
    repeat (5) tick();
    chk("ls_store_fin", 32'({state, finished}), 32'({4'd6, 1'b1}));
    tick();
    chk("ls_cnt", 32'(instr_count), 32'd2);

    // Run dropped during EXECUTE still completes the instruction
    do_reset();
    opcode = ALU;
    run    = 1'b1;
    repeat (3) tick();
    chk("drop_exec", 32'(state), 32'd3);
    run = 1'b0;
    repeat (2) tick();
    chk("drop_fin", 32'({state, finished}), 32'({4'd6, 1'b1}));
    tick();
    chk("drop_idle", 32'(state), 32'd0);
    chk("drop_cnt", 32'(instr_count), 32'd1);
    repeat (3) tick();
    chk("drop_stay", 32'(state), 32'd0);

    // Reset pulse during MEMORY of a STORE drops the strobe at once
    do_reset();
    opcode = STORE;
    run    = 1'b1;
    repeat (4) tick();
    chk("rst_mem_dm", 32'({state, dm_write_en}), 32'({4'd4, 1'b1}));
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mem_outs", 32'(outs()), 32'(model(4'd0, STORE)));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst_resume", 32'(state), 32'd1);
    chk("rst_cnt", 32'(instr_count), 32'd0);

    // ERROR absorbs with run held and the count frozen
    do_reset();
    opcode = ALU;
    run    = 1'b1;
    repeat (5) tick();
    opcode = 7'b1111111;
    repeat (22) tick();
    chk("err_hold", 32'(outs()), 32'(model(4'd8, 7'b1111111)));
    chk("err_cnt", 32'(instr_count), 32'd1);

    // HALT absorbs likewise
    do_reset();
    opcode = 7'b1110011;
    run    = 1'b1;
    repeat (20) tick();
    chk("halt_hold", 32'(outs()), 32'(model(4'd7, 7'b1110011)));
    chk("halt_cnt", 32'(instr_count), 32'd0);

    // Retire counter wraps 15 -> 0 with a 4-bit counter
    do_reset();
    opcode = BR;
    run    = 1'b1;
    repeat (61) tick();
    chk("wrap_15", 32'({state, instr_count}), 32'({4'd1, 4'd15}));
    repeat (4) tick();
    chk("wrap_0", 32'({state, instr_count}), 32'({4'd1, 4'd0}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // One-hot strobe property checked every cycle
  always @(negedge clk) begin
    if (rst_n &&
        ($countones({fetch, decode, dm_write_en,
                     rf_write_en, finished}) > 1)) begin
      checks++;
      errors++;
      $display("FAIL onehot: got %b expected at most one set",
               {fetch, decode, dm_write_en, rf_write_en, finished});
    end
  end

endmodule
